// File: rtl/cordic_arbiter.sv
// cordic_arbiter
// Shares one CORDIC_MAIN hyperbolic/exponential core among N_REQ requesters.
// A requester is granted, its angle is driven to the core for CORE_LAT
// cycles, the core's COSH/SINH/EXP are captured and returned, tagged with
// the requester ID, on a valid/ready response channel.
//
// Build option:
//   CORDIC_ARB_PRIO_EN  - requester 0 gets strict priority over the others,
//                         which remain round-robin among themselves.
//                         Undefined (default): pure round-robin.
//
// Reset: rst is asynchronous and active-low.

module cordic_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int DATA_W   = 32,
    parameter int CORE_LAT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_angle,
    output logic [DATA_W-1:0]       core_angle,
    input  logic [DATA_W-1:0]       core_cosh,
    input  logic [DATA_W-1:0]       core_sinh,
    input  logic [DATA_W-1:0]       core_exp,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_cosh,
    output logic [DATA_W-1:0]       rsp_sinh,
    output logic [DATA_W-1:0]       rsp_exp,
    output logic                    busy
);

    // Counter must hold CORE_LAT-1; one spare bit keeps CORE_LAT=1 legal.
    localparam int CNT_W = $clog2(CORE_LAT) + 1;
    // Candidate index needs one extra bit so ptr+k can exceed N_REQ-1
    // before the single wrap-around subtraction.
    localparam int CW = ID_W + 1;
    localparam logic [CW-1:0]    N_REQ_W   = CW'(N_REQ);
    localparam logic [ID_W-1:0]  PTR_RST   = ID_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(CORE_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [DATA_W-1:0]   core_angle_q, core_angle_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_cosh_q, rsp_cosh_d;
    logic [DATA_W-1:0]   rsp_sinh_q, rsp_sinh_d;
    logic [DATA_W-1:0]   rsp_exp_q, rsp_exp_d;
    logic                busy_q, busy_d;

    logic                grant_found_s;
    logic [ID_W-1:0]     grant_idx_s;
    logic [CW-1:0]       cand_s;
    logic [N_REQ-1:0]    grant_onehot_s;
    logic [DATA_W-1:0]   grant_angle_s;
    logic [N_REQ-1:0]    req_ready_s;

    // Arbitration: first asserted request searching ptr+1, ptr+2, ... mod N_REQ
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_s = {1'b0, ptr_q} + CW'(k);
            if (cand_s >= N_REQ_W) begin
                cand_s = cand_s - N_REQ_W;
            end else begin
                cand_s = cand_s;
            end
            if (!grant_found_s && req_valid[cand_s[ID_W-1:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s[ID_W-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
`ifdef CORDIC_ARB_PRIO_EN
        // Requester 0 overrides the rotating search whenever it is asking.
        if (req_valid[0]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = '0;
        end else begin
            grant_idx_s   = grant_idx_s;
        end
`endif
    end

    // Decode the grant index into a one-hot vector and select its angle
    always_comb begin
        grant_onehot_s = '0;
        grant_angle_s  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx_s == ID_W'(i)) begin
                grant_onehot_s[i] = 1'b1;
                grant_angle_s     = req_angle[i*DATA_W +: DATA_W];
            end else begin
                grant_onehot_s[i] = 1'b0;
            end
        end
    end

    // FSM next-state and datapath update
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        core_angle_d = core_angle_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_cosh_d   = rsp_cosh_q;
        rsp_sinh_d   = rsp_sinh_q;
        rsp_exp_d    = rsp_exp_q;
        req_ready_s  = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    req_ready_s  = grant_onehot_s;
                    core_angle_d = grant_angle_s;
                    rsp_id_d     = grant_idx_s;
                    cnt_d        = CNT_LOAD;
                    state_d      = ST_WAIT;
`ifdef CORDIC_ARB_PRIO_EN
                    // Priority grants to requester 0 leave the rotation alone.
                    if (grant_idx_s != '0) begin
                        ptr_d = grant_idx_s;
                    end else begin
                        ptr_d = ptr_q;
                    end
`else
                    ptr_d = grant_idx_s;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_cosh_d  = core_cosh;
                    rsp_sinh_d  = core_sinh;
                    rsp_exp_d   = core_exp;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                // Unreachable encoding: recover to a quiet idle.
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ptr_q        <= PTR_RST;
            core_angle_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_cosh_q   <= '0;
            rsp_sinh_q   <= '0;
            rsp_exp_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            core_angle_q <= core_angle_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_cosh_q   <= rsp_cosh_d;
            rsp_sinh_q   <= rsp_sinh_d;
            rsp_exp_q    <= rsp_exp_d;
            busy_q       <= busy_d;
        end
    end

    // The accept strobe is combinational so a request is taken in the
    // same IDLE cycle the grant is decided.
    assign req_ready  = req_ready_s;
    assign core_angle = core_angle_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_cosh   = rsp_cosh_q;
    assign rsp_sinh   = rsp_sinh_q;
    assign rsp_exp    = rsp_exp_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter: single request, round-robin order and
// period, response backpressure, reset mid-operation, optional requester-0
// priority (CORDIC_ARB_PRIO_EN), and a CORE_LAT=1 instance.

module tb_cordic_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int DW  = 32;
    localparam int LAT = 16;

    logic            clk;
    logic            rst;

    // Main instance (CORE_LAT = 16)
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_angle;
    logic [DW-1:0]   core_angle;
    logic [DW-1:0]   core_cosh, core_sinh, core_exp;
    logic            rsp_valid, rsp_ready;
    logic [IDW-1:0]  rsp_id;
    logic [DW-1:0]   rsp_cosh, rsp_sinh, rsp_exp;
    logic            busy;

    // Second instance (CORE_LAT = 1)
    logic [N-1:0]    req_valid1;
    logic [N-1:0]    req_ready1;
    logic [N*DW-1:0] req_angle1;
    logic [DW-1:0]   core_angle1;
    logic [DW-1:0]   core_cosh1, core_sinh1, core_exp1;
    logic            rsp_valid1, rsp_ready1;
    logic [IDW-1:0]  rsp_id1;
    logic [DW-1:0]   rsp_cosh1, rsp_sinh1, rsp_exp1;
    logic            busy1;

    int n_checks;
    int n_errors;

    // Core stubs: cosh=angle+1, sinh=angle+2, exp=angle+3
    assign core_cosh  = core_angle + 32'd1;
    assign core_sinh  = core_angle + 32'd2;
    assign core_exp   = core_angle + 32'd3;
    assign core_cosh1 = core_angle1 + 32'd1;
    assign core_sinh1 = core_angle1 + 32'd2;
    assign core_exp1  = core_angle1 + 32'd3;

    cordic_arbiter #(.N_REQ(N), .ID_W(IDW), .DATA_W(DW), .CORE_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_angle(req_angle),
        .core_angle(core_angle), .core_cosh(core_cosh), .core_sinh(core_sinh),
        .core_exp(core_exp), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_cosh(rsp_cosh), .rsp_sinh(rsp_sinh),
        .rsp_exp(rsp_exp), .busy(busy)
    );

    cordic_arbiter #(.N_REQ(N), .ID_W(IDW), .DATA_W(DW), .CORE_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_angle(req_angle1),
        .core_angle(core_angle1), .core_cosh(core_cosh1), .core_sinh(core_sinh1),
        .core_exp(core_exp1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_id(rsp_id1), .rsp_cosh(rsp_cosh1), .rsp_sinh(rsp_sinh1),
        .rsp_exp(rsp_exp1), .busy(busy1)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int onehot_to_id(input logic [N-1:0] v);
        int id;
        id = -1;
        for (int i = 0; i < N; i++) begin
            if (v[i]) id = i;
        end
        return id;
    endfunction

    // Collect n grants of the main instance; returns ids and sample cycles
    task automatic collect_grants(input int n, output int ids[8], output int cyc[8], output int got);
        int c;
        got = 0;
        c = 0;
        while (got < n && c < 400) begin
            #1;
            if (req_ready != '0) begin
                ids[got] = onehot_to_id(req_ready);
                cyc[got] = c;
                got++;
            end
            tick();
            c++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (busy && c < 60) begin
            tick();
            c++;
        end
        check_eq(tag, 32'(busy), 32'd0);
    endtask

    logic [DW-1:0] ang;
    int bad;
    int ids[8];
    int cyc[8];
    int got;
    int exp_prio[4];

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        req_valid  = '0;
        req_angle  = '0;
        rsp_ready  = 1'b0;
        req_valid1 = '0;
        req_angle1 = '0;
        rsp_ready1 = 1'b0;
        #2 rst = 1'b0;
        tick();
        tick();

        // ---------------- reset state ----------------
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_core_angle", core_angle, 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
        check_eq("rst_rsp_cosh", rsp_cosh, 32'd0);
        check_eq("rst_rsp_sinh", rsp_sinh, 32'd0);
        check_eq("rst_rsp_exp", rsp_exp, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        tick();

        // ---------------- single request from requester 2 ----------------
        ang = -32'sd452200;
        req_angle[2*DW +: DW] = ang;
        req_valid = 4'b0100;
        #1;
        check_eq("single_ready", 32'(req_ready), 32'h4);
        tick();                                  // E0
        check_eq("single_ready_drop", 32'(req_ready), 32'd0);
        check_eq("single_core_angle", core_angle, ang);
        check_eq("single_busy", 32'(busy), 32'd1);
        req_valid = '0;
        bad = 0;
        for (int i = 1; i < LAT; i++) begin
            tick();                              // E0+1 .. E0+15
            if (core_angle !== ang || rsp_valid !== 1'b0) bad++;
        end
        check_eq("single_hold", 32'(bad), 32'd0);
        tick();                                  // E0+16
        check_eq("single_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("single_rsp_id", 32'(rsp_id), 32'd2);
        check_eq("single_cosh", rsp_cosh, -32'sd452199);
        check_eq("single_sinh", rsp_sinh, -32'sd452198);
        check_eq("single_exp", rsp_exp, -32'sd452197);

        // ---------------- backpressure, new request pending ----------------
        req_angle[1*DW +: DW] = 32'h0001_0000;
        req_valid = 4'b0010;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 4'b0000 ||
                rsp_cosh !== -32'sd452199 || rsp_id !== 2'd2) bad++;
        end
        check_eq("bp_stable", 32'(bad), 32'd0);
        rsp_ready = 1'b1;
        tick();
        check_eq("bp_release_valid", 32'(rsp_valid), 32'd0);
        check_eq("bp_release_busy", 32'(busy), 32'd0);
        check_eq("idle_keeps_cosh", rsp_cosh, -32'sd452199);
        check_eq("rr_after_2", 32'(req_ready), 32'h2);

        // ---------------- reset mid-WAIT ----------------
        tick();                                  // grant requester 1
        check_eq("grant1_angle", core_angle, 32'h0001_0000);
        check_eq("grant1_id", 32'(rsp_id), 32'd1);
        req_valid = '0;
        for (int i = 0; i < 5; i++) tick();
        #2 rst = 1'b0;
        #1;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_core_angle", core_angle, 32'd0);
        check_eq("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
        check_eq("mid_rst_cosh", rsp_cosh, 32'd0);
        tick();
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (rsp_valid !== 1'b0) bad++;
        end
        check_eq("dropped_no_rsp", 32'(bad), 32'd0);

        // ---------------- round-robin, all requesting ----------------
        for (int i = 0; i < N; i++) req_angle[i*DW +: DW] = 32'(i * 1000 + 7);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        collect_grants(5, ids, cyc, got);
        check_eq("rr_count", 32'(got), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < got) begin
                check_eq($sformatf("rr_id%0d", k), 32'(ids[k]), 32'(k % N));
                if (k > 0) check_eq($sformatf("rr_gap%0d", k), 32'(cyc[k] - cyc[k-1]), 32'd18);
            end
        end
        req_valid = '0;
        wait_idle("rr_idle");

        // ---------------- requester 0 vs 3 ----------------
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
`ifdef CORDIC_ARB_PRIO_EN
        exp_prio = '{0, 0, 0, 0};
`else
        exp_prio = '{0, 3, 0, 3};
`endif
        req_valid = 4'b1001;
        collect_grants(4, ids, cyc, got);
        check_eq("prio_count", 32'(got), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < got) check_eq($sformatf("prio_id%0d", k), 32'(ids[k]), 32'(exp_prio[k]));
        end
        req_valid = '0;
        wait_idle("prio_idle");

        // ---------------- CORE_LAT = 1 instance ----------------
        req_angle1[0 +: DW] = 32'd100;
        rsp_ready1 = 1'b1;
        req_valid1 = 4'b0001;
        #1;
        check_eq("lat1_ready", 32'(req_ready1), 32'h1);
        tick();                                  // E0
        check_eq("lat1_e0_valid", 32'(rsp_valid1), 32'd0);
        check_eq("lat1_e0_angle", core_angle1, 32'd100);
        check_eq("lat1_e0_busy", 32'(busy1), 32'd1);
        tick();                                  // E0+1: capture
        check_eq("lat1_rsp_valid", 32'(rsp_valid1), 32'd1);
        check_eq("lat1_rsp_cosh", rsp_cosh1, 32'd101);
        check_eq("lat1_rsp_exp", rsp_exp1, 32'd103);
        check_eq("lat1_rsp_id", 32'(rsp_id1), 32'd0);
        check_eq("lat1_ready_resp", 32'(req_ready1), 32'd0);
        tick();                                  // E0+2: back in IDLE
        check_eq("lat1_idle_valid", 32'(rsp_valid1), 32'd0);
        check_eq("lat1_period", 32'(req_ready1), 32'h1);
        req_valid1 = '0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cordic_arbiter.md
# cordic_arbiter

Round-robin scheduler that shares one CORDIC_MAIN hyperbolic/exponential core among N_REQ requesters. Each requester presents a Q16.16 angle with a valid/ready handshake. The arbiter grants one requester, holds the core's angle input stable for the core's settling latency, then captures COSH/SINH/EXP. It returns the results tagged with the requester ID on a valid/ready response channel. It sits between the client blocks and the single CORDIC_MAIN instance.

## Interface
- N_REQ, 4: number of requesters, 2..16.
- ID_W, 2: requester ID width; must equal clog2(N_REQ).
- DATA_W, 32: angle and result width (Q16.16 two's complement).
- CORE_LAT, 16: cycles core_angle is held before core outputs are sampled; ≥1.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept, one-hot or zero.
- req_angle  in  N_REQ*DATA_W  packed angles; requester i at bits [i*DATA_W +: DATA_W].
- core_angle  out  DATA_W  registered angle to CORDIC_MAIN.
- core_cosh, core_sinh, core_exp  in  DATA_W each  core results.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  index of the served requester.
- rsp_cosh, rsp_sinh, rsp_exp  out  DATA_W each  captured results.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states:
  - IDLE: if any req_valid, the grant g is chosen combinationally and req_ready[g]=1 for that cycle. At the clock edge: core_angle←req_angle[g], rsp_id←g, cnt←CORE_LAT-1, ptr←g, go to WAIT. If no req_valid, stay in IDLE.
  - WAIT: core_angle is held. At each edge, if cnt≠0 then cnt←cnt-1. If cnt==0, capture core_cosh/sinh/exp into rsp_*, set rsp_valid←1, go to RESP.
  - RESP: rsp_* are held. On an edge with rsp_ready=1, rsp_valid←0 and go to IDLE.
- Round-robin: search order is ptr+1, ptr+2, … modulo N_REQ. The first asserted req_valid wins. ptr resets to N_REQ-1, so requester 0 is first after reset.
- req_ready is 0 in WAIT and RESP. A requester must hold req_valid and req_angle until it sees ready.
- Only one request is in flight at a time; there is no queueing.
- rsp_* and core_angle keep their last values in IDLE. Only rsp_valid qualifies the response.
- cnt width is clog2(CORE_LAT)+1 bits.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, req_ready=0, core_angle=0, rsp_valid=0, rsp_id=0, rsp_cosh=rsp_sinh=rsp_exp=0, busy=0, cnt=0, ptr=N_REQ-1.
- Let E0 be the request handshake edge:
  - core_angle is valid from E0.
  - Capture happens at edge E0+CORE_LAT.
  - rsp_valid is high from E0+CORE_LAT.
- If rsp_ready is held at 1, the FSM returns to IDLE at E0+CORE_LAT+1. The next handshake is at E0+CORE_LAT+2, giving a minimum period of CORE_LAT+2 cycles.
- rsp_ready=1 while not in RESP is ignored.
- req_valid arriving during WAIT or RESP waits. It is arbitrated in the next IDLE cycle with all other pending requests.
- Reset asserted mid-operation: the in-flight request is dropped with no response. The requester was already acknowledged and must not expect a result.
- If req_valid[g] drops in the same cycle it is granted, that is a protocol violation and the behaviour is undefined.

## Configuration
- CORDIC_ARB_PRIO_EN defined:
  - Requester 0 has strict priority. If req_valid[0]=1 in IDLE, g=0 regardless of ptr.
  - ptr is updated only when g≠0.
  - The other requesters stay round-robin.
- Not defined: pure round-robin across all N_REQ requesters, as described above.

## Test plan
- Single request: reset, then req_valid[2]=1 with angle -452200 (≈-6.9), and the core stub returns cosh=angle+1, sinh=angle+2, exp=angle+3.
  - Expect req_ready[2] for one cycle.
  - Expect core_angle=-452200 for exactly 16 cycles.
  - Expect rsp_valid at E0+16 with rsp_id=2 and rsp_cosh/sinh/exp = -452199/-452198/-452197.
- Round-robin: all four req_valid held high with rsp_ready=1.
  - Grant order is 0,1,2,3,0.
  - Successive handshakes are 18 cycles apart.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid.
  - rsp_* stay stable, busy=1, and no req_ready is asserted.
  - Raising rsp_ready returns the FSM to IDLE next cycle.
- Reset mid-WAIT: assert rst low 5 cycles after a grant.
  - All outputs go to their reset values immediately.
  - No rsp_valid ever appears for that request.
  - After release, requester 0 is granted first.
- CORDIC_ARB_PRIO_EN: with req_valid[0] and req_valid[3] both held high continuously, requester 0 is served every time and requester 3 is never granted. With the macro undefined, the bench alternates 0,3,0,3.
- CORE_LAT=1 build: capture occurs on the edge after the handshake, and the handshake period is 3 cycles.
